// File: rtl/keypad_pkg.sv
// Shared constants and state encoding for the keypad entry controller.
// KEYPAD_LOCKOUT_EN adds the lockout state to the encoding.
package keypad_pkg;

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] DISP_ERR   = 4'hA;
  localparam logic [3:0] DISP_BLANK = 4'hF;

  typedef enum logic [2:0] {
    StIdle,
    StEntry,
    StCheck,
    StUnlocked,
`ifdef KEYPAD_LOCKOUT_EN
    StError,
    StLockout
`else
    StError
`endif
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable down-counter; done is high while the count is zero.
module hold_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [Width-1:0] value,
  output logic             done
);

  logic [Width-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= value;
    end else if (r_count != '0) begin
      r_count <= r_count - Width'(1);
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/keypad_entry.sv
// Keypad entry controller: collects up to four BCD digits, checks them against CODE and
// drives the display and lock outputs. KEYPAD_LOCKOUT_EN enables the failed-attempt lockout.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned UNLOCK_CYCLES  = 100_000_000,
  parameter int unsigned ERROR_CYCLES   = 50_000_000,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned LOCKOUT_CYCLES = 500_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [3:0] DispVal,
  output logic [2:0] press_count,
  output logic       unlocked,
  output logic       error_flag
);

  localparam int unsigned TimerMax = max3(UNLOCK_CYCLES, ERROR_CYCLES, LOCKOUT_CYCLES);
  localparam int unsigned TimerW   = $clog2(TimerMax);

  state_e      r_state;
  logic [15:0] r_buf;
  logic [2:0]  r_cnt;
  logic [3:0]  r_disp;
  logic        r_unlocked;
  logic        r_error;

  logic              w_is_digit;
  logic              w_match;
  logic              w_load;
  logic [TimerW-1:0] w_value;
  logic              w_done;

`ifdef KEYPAD_LOCKOUT_EN
  localparam int unsigned FailW = $clog2(MAX_TRIES + 1);
  localparam logic [FailW-1:0] FailMax = FailW'(MAX_TRIES);
  logic [FailW-1:0] r_fail;
`else
  logic w_unused_tries;
  assign w_unused_tries = (MAX_TRIES != 0);
`endif

  assign w_is_digit = (key_code < 4'd10);
  assign w_match    = (r_cnt == 3'd4) && (r_buf == CODE);

  // Timer is loaded on entry to every timed state; it counts CYCLES-1 down to zero.
  always_comb begin
    w_load  = 1'b0;
    w_value = '0;
    if (r_state == StCheck) begin
      w_load  = 1'b1;
      w_value = w_match ? TimerW'(UNLOCK_CYCLES - 1) : TimerW'(ERROR_CYCLES - 1);
    end
`ifdef KEYPAD_LOCKOUT_EN
    else if (r_state == StError && w_done && r_fail == FailMax) begin
      w_load  = 1'b1;
      w_value = TimerW'(LOCKOUT_CYCLES - 1);
    end
`endif
  end

  hold_timer #(
    .Width(TimerW)
  ) u_hold_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (w_load),
    .value  (w_value),
    .done   (w_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= StIdle;
      r_buf      <= '0;
      r_cnt      <= '0;
      r_disp     <= DISP_BLANK;
      r_unlocked <= 1'b0;
      r_error    <= 1'b0;
`ifdef KEYPAD_LOCKOUT_EN
      r_fail     <= '0;
`endif
    end else begin
      unique case (r_state)
        StIdle: begin
          if (key_valid && w_is_digit) begin
            r_buf   <= {12'h000, key_code};
            r_cnt   <= 3'd1;
            r_disp  <= key_code;
            r_state <= StEntry;
          end
        end
        StEntry: begin
          if (key_valid) begin
            if (w_is_digit) begin
              if (r_cnt != 3'd4) begin
                r_buf  <= {r_buf[11:0], key_code};
                r_cnt  <= r_cnt + 3'd1;
                r_disp <= key_code;
              end
            end else if (key_code == KEY_CLEAR) begin
              r_buf   <= '0;
              r_cnt   <= '0;
              r_disp  <= DISP_BLANK;
              r_state <= StIdle;
            end else if (key_code == KEY_ENTER) begin
              r_state <= StCheck;
            end
          end
        end
        StCheck: begin
          if (w_match) begin
            r_unlocked <= 1'b1;
            r_state    <= StUnlocked;
`ifdef KEYPAD_LOCKOUT_EN
            r_fail     <= '0;
`endif
          end else begin
            r_error <= 1'b1;
            r_disp  <= DISP_ERR;
            r_cnt   <= 3'd4;
            r_state <= StError;
`ifdef KEYPAD_LOCKOUT_EN
            if (r_fail != FailMax) r_fail <= r_fail + FailW'(1);
`endif
          end
        end
        StUnlocked: begin
          if (w_done) begin
            r_unlocked <= 1'b0;
            r_buf      <= '0;
            r_cnt      <= '0;
            r_disp     <= DISP_BLANK;
            r_state    <= StIdle;
          end
        end
        StError: begin
          if (w_done) begin
`ifdef KEYPAD_LOCKOUT_EN
            if (r_fail == FailMax) begin
              r_state <= StLockout;
            end else begin
              r_error <= 1'b0;
              r_buf   <= '0;
              r_cnt   <= '0;
              r_disp  <= DISP_BLANK;
              r_state <= StIdle;
            end
`else
            r_error <= 1'b0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_disp  <= DISP_BLANK;
            r_state <= StIdle;
`endif
          end
        end
`ifdef KEYPAD_LOCKOUT_EN
        StLockout: begin
          if (w_done) begin
            r_error <= 1'b0;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_disp  <= DISP_BLANK;
            r_fail  <= '0;
            r_state <= StIdle;
          end
        end
`endif
        default: r_state <= StIdle;
      endcase
    end
  end

  assign DispVal     = r_disp;
  assign press_count = r_cnt;
  assign unlocked    = r_unlocked;
  assign error_flag  = r_error;

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: each stimulus cycle queues the hand-computed outputs
// expected after its clock edge; a monitor pops and compares one entry per edge.
module tb_keypad_entry;

  logic       clk;
  logic       reset_n;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] DispVal;
  logic [2:0] press_count;
  logic       unlocked;
  logic       error_flag;

  int n_checks;
  int n_errors;

  typedef struct {
    logic [3:0] d;
    logic [2:0] c;
    logic       u;
    logic       e;
    string      tag;
  } exp_t;

  exp_t q[$];
  exp_t m_exp;

  keypad_entry #(
    .CODE          (16'h1234),
    .UNLOCK_CYCLES (8),
    .ERROR_CYCLES  (5),
    .MAX_TRIES     (2),
    .LOCKOUT_CYCLES(12)
  ) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .DispVal    (DispVal),
    .press_count(press_count),
    .unlocked   (unlocked),
    .error_flag (error_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: outputs are registered, so sample 1 time unit after each rising edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_exp = q.pop_front();
      n_checks++;
      if (DispVal !== m_exp.d || press_count !== m_exp.c || unlocked !== m_exp.u ||
          error_flag !== m_exp.e) begin
        n_errors++;
        $display("FAIL %s: got disp=%h cnt=%0d unl=%b err=%b, expected disp=%h cnt=%0d unl=%b err=%b",
                 m_exp.tag, DispVal, press_count, unlocked, error_flag,
                 m_exp.d, m_exp.c, m_exp.u, m_exp.e);
      end
    end
  end

  task automatic step(input logic v, input logic [3:0] k, input logic [3:0] d,
                      input logic [2:0] c, input logic u, input logic e, input string tag);
    exp_t x;
    @(negedge clk);
    key_valid = v;
    key_code  = k;
    x.d = d; x.c = c; x.u = u; x.e = e; x.tag = tag;
    q.push_back(x);
    @(posedge clk);
  endtask

  task automatic hold(input int n, input logic [3:0] d, input logic [2:0] c, input logic u,
                      input logic e, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, d, c, u, e, tag);
  endtask

  task automatic chk_now(input string tag);
    n_checks++;
    if (DispVal !== 4'hF || press_count !== 3'd0 || unlocked !== 1'b0 || error_flag !== 1'b0) begin
      n_errors++;
      $display("FAIL %s: got disp=%h cnt=%0d unl=%b err=%b, expected disp=f cnt=0 unl=0 err=0",
               tag, DispVal, press_count, unlocked, error_flag);
    end
  endtask

  task automatic async_reset(input string tag);
    #2;
    key_valid = 1'b0;
    reset_n   = 1'b0;
    #1;
    chk_now(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    reset_n   = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_now("reset_state");
    @(negedge clk);
    reset_n = 1'b1;

    // Non-digit keys in IDLE have no effect.
    step(1'b1, 4'hA, 4'hF, 3'd0, 1'b0, 1'b0, "idle_clear");
    step(1'b1, 4'hB, 4'hF, 3'd0, 1'b0, 1'b0, "idle_enter");
    step(1'b1, 4'hC, 4'hF, 3'd0, 1'b0, 1'b0, "idle_ignored");

    // Correct code, back-to-back strobes; one key during UNLOCKED is discarded.
    step(1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b0, "a_d1");
    step(1'b1, 4'h2, 4'h2, 3'd2, 1'b0, 1'b0, "a_d2");
    step(1'b1, 4'h3, 4'h3, 3'd3, 1'b0, 1'b0, "a_d3");
    step(1'b1, 4'h4, 4'h4, 3'd4, 1'b0, 1'b0, "a_d4");
    step(1'b1, 4'hB, 4'h4, 3'd4, 1'b0, 1'b0, "a_check");
    hold(3, 4'h4, 3'd4, 1'b1, 1'b0, "a_unlocked");
    step(1'b1, 4'h5, 4'h4, 3'd4, 1'b1, 1'b0, "a_key_in_unlocked");
    hold(4, 4'h4, 3'd4, 1'b1, 1'b0, "a_unlocked");
    hold(2, 4'hF, 3'd0, 1'b0, 1'b0, "a_back_idle");

    // Wrong code: first failure.
    step(1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b0, "b_d1");
    step(1'b1, 4'h2, 4'h2, 3'd2, 1'b0, 1'b0, "b_d2");
    step(1'b1, 4'h3, 4'h3, 3'd3, 1'b0, 1'b0, "b_d3");
    step(1'b1, 4'h5, 4'h5, 3'd4, 1'b0, 1'b0, "b_d4");
    step(1'b1, 4'hB, 4'h5, 3'd4, 1'b0, 1'b0, "b_check");
    hold(5, 4'hA, 3'd4, 1'b0, 1'b1, "b_error");
    hold(2, 4'hF, 3'd0, 1'b0, 1'b0, "b_back_idle");

    // Short entry: second failure.
    step(1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b0, "c_d1");
    step(1'b1, 4'h2, 4'h2, 3'd2, 1'b0, 1'b0, "c_d2");
    step(1'b1, 4'hB, 4'h2, 3'd2, 1'b0, 1'b0, "c_check");
    hold(4, 4'hA, 3'd4, 1'b0, 1'b1, "c_error");
    step(1'b1, 4'h7, 4'hA, 3'd4, 1'b0, 1'b1, "c_key_in_error");
`ifdef KEYPAD_LOCKOUT_EN
    hold(5, 4'hA, 3'd4, 1'b0, 1'b1, "c_lockout");
    step(1'b1, 4'h1, 4'hA, 3'd4, 1'b0, 1'b1, "c_key_in_lockout");
    step(1'b1, 4'hB, 4'hA, 3'd4, 1'b0, 1'b1, "c_enter_in_lockout");
    hold(5, 4'hA, 3'd4, 1'b0, 1'b1, "c_lockout");
`endif
    hold(2, 4'hF, 3'd0, 1'b0, 1'b0, "c_back_idle");

    // Fifth digit dropped, then unlock, then clear.
    step(1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b0, "d_d1");
    step(1'b1, 4'h2, 4'h2, 3'd2, 1'b0, 1'b0, "d_d2");
    step(1'b1, 4'h3, 4'h3, 3'd3, 1'b0, 1'b0, "d_d3");
    step(1'b1, 4'h4, 4'h4, 3'd4, 1'b0, 1'b0, "d_d4");
    step(1'b1, 4'h9, 4'h4, 3'd4, 1'b0, 1'b0, "d_fifth_dropped");
    step(1'b1, 4'hB, 4'h4, 3'd4, 1'b0, 1'b0, "d_check");
    hold(8, 4'h4, 3'd4, 1'b1, 1'b0, "d_unlocked");
    step(1'b0, 4'h0, 4'hF, 3'd0, 1'b0, 1'b0, "d_back_idle");
    step(1'b1, 4'h7, 4'h7, 3'd1, 1'b0, 1'b0, "d_d7");
    step(1'b1, 4'hA, 4'hF, 3'd0, 1'b0, 1'b0, "d_clear");
    hold(1, 4'hF, 3'd0, 1'b0, 1'b0, "d_idle");

    // Asynchronous reset mid-UNLOCKED.
    step(1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b0, "e_d1");
    step(1'b1, 4'h2, 4'h2, 3'd2, 1'b0, 1'b0, "e_d2");
    step(1'b1, 4'h3, 4'h3, 3'd3, 1'b0, 1'b0, "e_d3");
    step(1'b1, 4'h4, 4'h4, 3'd4, 1'b0, 1'b0, "e_d4");
    step(1'b1, 4'hB, 4'h4, 3'd4, 1'b0, 1'b0, "e_check");
    hold(3, 4'h4, 3'd4, 1'b1, 1'b0, "e_unlocked");
    async_reset("e_reset_in_unlocked");
    hold(3, 4'hF, 3'd0, 1'b0, 1'b0, "e_after_reset");

    // Asynchronous reset mid-entry after three digits.
    step(1'b1, 4'h1, 4'h1, 3'd1, 1'b0, 1'b0, "f_d1");
    step(1'b1, 4'h2, 4'h2, 3'd2, 1'b0, 1'b0, "f_d2");
    step(1'b1, 4'h3, 4'h3, 3'd3, 1'b0, 1'b0, "f_d3");
    async_reset("f_reset_in_entry");
    step(1'b1, 4'h5, 4'h5, 3'd1, 1'b0, 1'b0, "f_restart");
    step(1'b0, 4'h0, 4'h5, 3'd1, 1'b0, 1'b0, "f_hold");

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
